// File: rtl/emmc_xfer_ctrl.sv
// emmc_xfer_ctrl: splits multi-block eMMC requests into single-block transfers staged through a one-block buffer
// Ports: clk_i/arst_ni clock and async active-low reset; req_* request handshake (we, first block, count);
//   wr_* write bytes in; rd_* read bytes out; done_o/err_o completion pulses;
//   sm_* start/ready handshake, block address/count and byte stream of the eMMC state machine.
module emmc_xfer_ctrl #(
  parameter int BLK_BYTES = 512,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [31:0]          req_blk_idx_i,
  input  logic [CNT_WIDTH-1:0] req_blk_cnt_i,
  input  logic [7:0]           wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  output logic [7:0]           rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic                 done_o,
  output logic                 err_o,
  input  logic                 sm_ready_i,
  output logic                 sm_start_o,
  output logic                 sm_we_o,
  output logic [31:0]          sm_blk_idx_o,
  output logic [CNT_WIDTH-1:0] sm_blk_cnt_o,
  output logic [7:0]           sm_dat_o,
  input  logic [7:0]           sm_dat_i,
  input  logic                 sm_dvalid_i
);
  localparam int AW = $clog2(BLK_BYTES);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LAST = PW'(BLK_BYTES - 1);
  localparam logic [PW-1:0] FULL = PW'(BLK_BYTES);
  typedef enum logic [2:0] {IDLE, WR_FILL, WR_ISSUE, WR_XFER, RD_ISSUE, RD_XFER, RD_DRAIN, NEXT} state_t;
  state_t r_state, w_state_nxt;
  logic [7:0] r_mem [BLK_BYTES];
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [31:0] r_addr;
  logic [7:0] r_rdat;
  logic [1:0] r_hold;
  logic r_we, r_err, r_ovf, r_alive, r_rdy_q, r_drain_rdy;
  logic w_xfer, w_rise, w_fill_beat, w_drain_beat, w_strobe, w_adv, w_mem_we, w_last, w_accept;
  assign w_accept     = req_valid_i && req_ready_o;
  assign w_xfer       = r_state == WR_XFER || r_state == RD_XFER;
  // ready rise ends a transfer, but only once the post-start blanking window has elapsed
  assign w_rise       = sm_ready_i && !r_rdy_q && r_hold == 2'd0;
  assign w_fill_beat  = r_state == WR_FILL && wr_valid_i;
  assign w_drain_beat = rd_valid_o && rd_ready_i;
  // strobes past a full block are dropped and only flagged
  assign w_strobe     = w_xfer && sm_dvalid_i && r_ptr != FULL;
  assign w_adv        = w_fill_beat || w_strobe || w_drain_beat;
  assign w_mem_we     = w_fill_beat || (r_state == RD_XFER && w_strobe);
  assign w_last       = r_remaining <= CNT_WIDTH'(1);
  // every phase change restarts the buffer pointer
  assign w_ptr_nxt    = w_state_nxt != r_state ? '0 : r_ptr + PW'(w_adv);
  assign req_ready_o  = r_state == IDLE && r_alive;
  assign wr_ready_o   = r_state == WR_FILL;
  assign rd_valid_o   = r_state == RD_DRAIN && r_drain_rdy;
  assign rd_data_o    = r_rdat;
  assign sm_dat_o     = r_rdat;
  assign done_o       = r_state == NEXT && w_last;
  assign err_o        = done_o && r_err;
  assign sm_start_o   = (r_state == WR_ISSUE || r_state == RD_ISSUE) && sm_ready_i;
  assign sm_we_o      = r_we;
  assign sm_blk_idx_o = r_addr;
  assign sm_blk_cnt_o = CNT_WIDTH'(1);
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_state_nxt = req_blk_cnt_i == '0 ? NEXT : req_we_i ? WR_FILL : RD_ISSUE;
      WR_FILL:  if (w_fill_beat && r_ptr == LAST) w_state_nxt = WR_ISSUE;
      WR_ISSUE: if (sm_ready_i) w_state_nxt = WR_XFER;
      WR_XFER:  if (w_rise) w_state_nxt = NEXT;
      RD_ISSUE: if (sm_ready_i) w_state_nxt = RD_XFER;
      RD_XFER:  if (w_rise) w_state_nxt = RD_DRAIN;
      RD_DRAIN: if (w_drain_beat && r_ptr == LAST) w_state_nxt = NEXT;
      NEXT:     w_state_nxt = w_last ? IDLE : r_we ? WR_FILL : RD_ISSUE;
      default:  w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) if (w_mem_we) r_mem[r_ptr[AW-1:0]] <= r_state == WR_FILL ? wr_data_i : sm_dat_i;
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_rdat      <= '0;
      r_alive     <= 1'b0;
      r_rdy_q     <= 1'b0;
      r_drain_rdy <= 1'b0;
      r_hold      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      // read port addressed by the next pointer so r_rdat always shows buf[ptr]
      r_rdat      <= r_mem[w_ptr_nxt[AW-1:0]];
      r_alive     <= 1'b1;
      r_rdy_q     <= sm_ready_i;
      r_drain_rdy <= r_state == RD_DRAIN;
      r_hold      <= sm_start_o ? 2'd2 : r_hold - 2'(r_hold != 2'd0);
      if (w_accept) begin
        r_we        <= req_we_i;
        r_addr      <= req_blk_idx_i;
        r_remaining <= req_blk_cnt_i;
        r_err       <= 1'b0;
      end
      if (r_state == NEXT && r_remaining != '0) begin
        r_remaining <= r_remaining - CNT_WIDTH'(1);
        r_addr      <= r_addr + 32'd1;
      end
      if (sm_start_o) r_ovf <= 1'b0;
      else if (w_xfer && sm_dvalid_i && r_ptr == FULL) r_ovf <= 1'b1;
      if (w_xfer && w_rise && (r_ptr != FULL || r_ovf)) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_emmc_xfer_ctrl.sv
// tb_emmc_xfer_ctrl: randomized bench for emmc_xfer_ctrl with a behavioural state machine and system model
module tb_emmc_xfer_ctrl;
  localparam int BLK = 512;
  localparam int CW = 16;
  logic clk_i = 1'b0;
  logic arst_ni = 1'b0;
  logic req_valid_i = 1'b0, req_we_i = 1'b0;
  logic [31:0] req_blk_idx_i = '0;
  logic [CW-1:0] req_blk_cnt_i = '0;
  logic [7:0] wr_data_i = '0, sm_dat_i = '0;
  logic wr_valid_i = 1'b0, rd_ready_i = 1'b0, sm_ready_i = 1'b1, sm_dvalid_i = 1'b0;
  logic req_ready_o, wr_ready_o, rd_valid_o, done_o, err_o, sm_start_o, sm_we_o;
  logic [7:0] rd_data_o, sm_dat_o;
  logic [31:0] sm_blk_idx_o;
  logic [CW-1:0] sm_blk_cnt_o;
  int n_checks = 0, n_errors = 0, n_starts = 0;
  bit expect_start = 1'b0;

  emmc_xfer_ctrl #(.BLK_BYTES(BLK), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_blk_idx_i(req_blk_idx_i), .req_blk_cnt_i(req_blk_cnt_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .done_o(done_o), .err_o(err_o),
    .sm_ready_i(sm_ready_i), .sm_start_o(sm_start_o), .sm_we_o(sm_we_o),
    .sm_blk_idx_o(sm_blk_idx_o), .sm_blk_cnt_o(sm_blk_cnt_o),
    .sm_dat_o(sm_dat_o), .sm_dat_i(sm_dat_i), .sm_dvalid_i(sm_dvalid_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) if (arst_ni && sm_start_o) begin
    n_starts++;
    check("start_window", expect_start, 1);
    check("start_sm_ready", sm_ready_i, 1);
  end

  task automatic run_req(input bit we, input logic [31:0] idx, input int cnt, input int short_blk,
                         input int short_n, input bit toggle, input int rst_at);
    logic [7:0] data [BLK+8];
    logic [31:0] a;
    logic [7:0] held;
    bit exp_err, stalled;
    int guard, ns, k;
    exp_err = 1'b0;
    guard = 0;
    while (!req_ready_o && guard < 100) begin tick; guard++; end
    check("req_ready", req_ready_o, 1);
    n_starts = 0;
    req_valid_i = 1'b1; req_we_i = we; req_blk_idx_i = idx; req_blk_cnt_i = CW'(cnt);
    tick;
    req_valid_i = 1'b0;
    #1;
    check("req_ready_busy", req_ready_o, 0);
    if (cnt == 0) begin
      check("zero_done", done_o, 1);
      check("zero_err", err_o, 0);
      tick;
      check("zero_idle", req_ready_o, 1);
      check("zero_starts", n_starts, 0);
      return;
    end
    for (int b = 0; b < cnt; b++) begin
      ns = (b == short_blk) ? short_n : BLK;
      a = idx + 32'(b);
      if (ns != BLK) exp_err = 1'b1;
      for (int i = 0; i < BLK + 8; i++) data[i] = 8'($urandom);
      if (we) begin
        if (b == 0) check("fill_first_ready", wr_ready_o, 1);
        k = 0; guard = 0;
        while (k < BLK && guard < 5000) begin
          wr_valid_i = $urandom_range(3) != 0; wr_data_i = data[k];
          #1;
          if (wr_valid_i && wr_ready_o) k++;
          tick; guard++;
        end
        wr_valid_i = 1'b0;
        check("fill_count", k, BLK);
      end
      sm_ready_i = 1'b0;
      repeat ($urandom_range(0, 3)) tick;
      sm_ready_i = 1'b1;
      expect_start = 1'b1;
      #1; guard = 0;
      while (!sm_start_o && guard < 50) begin tick; #1; guard++; end
      check("start_seen", sm_start_o, 1);
      check("start_idx", sm_blk_idx_o, a);
      check("start_we", sm_we_o, we);
      check("start_cnt", sm_blk_cnt_o, 1);
      if (we) check("wr_byte0_at_start", sm_dat_o, data[0]);
      tick;
      expect_start = 1'b0;
      if ($urandom_range(1) != 0) tick;
      sm_ready_i = 1'b0;
      for (int j = 0; j < ns;) begin
        if (j == rst_at) begin
          arst_ni = 1'b0;
          #1;
          check("rst_outs", {req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
                             sm_start_o, sm_we_o, sm_blk_idx_o, sm_dat_o}, 0);
          check("rst_cnt", sm_blk_cnt_o, 1);
          sm_dvalid_i = 1'b0; sm_ready_i = 1'b1;
          tick;
          check("rst_held_ready", req_ready_o, 0);
          arst_ni = 1'b1;
          tick;
          check("rst_release_ready", req_ready_o, 1);
          return;
        end
        sm_dvalid_i = $urandom_range(3) != 0; sm_dat_i = data[j];
        #1;
        if (sm_dvalid_i) begin
          if (we && j < BLK) check("wr_byte", sm_dat_o, data[j]);
          j++;
        end
        tick;
      end
      sm_dvalid_i = 1'b0;
      repeat ($urandom_range(0, 2)) tick;
      sm_ready_i = 1'b1;
      tick; #1;
      if (!we) begin
        check("drain_gap", rd_valid_o, 0);
        tick; #1;
        check("drain_latency", rd_valid_o, 1);
        k = 0; guard = 0; stalled = 1'b0; held = '0;
        while (k < BLK && guard < 5000) begin
          rd_ready_i = toggle ? guard % 2 == 0 : $urandom_range(2) != 0;
          #1;
          check("rd_valid", rd_valid_o, 1);
          if (stalled) check("rd_hold", rd_data_o, held);
          stalled = rd_valid_o && !rd_ready_i;
          held = rd_data_o;
          if (rd_valid_o && rd_ready_i) begin
            if (k < ns) check("rd_byte", rd_data_o, data[k]);
            k++;
          end
          tick; guard++;
        end
        rd_ready_i = 1'b0;
        check("drain_count", k, BLK);
        #1;
      end
      check("done", done_o, b == cnt - 1);
      check("err", err_o, b == cnt - 1 && exp_err);
    end
    tick;
    check("idle_after_done", req_ready_o, 1);
    check("start_count", n_starts, cnt);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #3;
    check("rst_outs_init", {req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
                            sm_start_o, sm_we_o, sm_blk_idx_o, sm_dat_o}, 0);
    check("rst_cnt_init", sm_blk_cnt_o, 1);
    arst_ni = 1'b1;
    tick;
    check("ready_after_rst", req_ready_o, 1);
    run_req(1'b1, 32'h10, 1, -1, 0, 1'b0, -1);
    run_req(1'b0, 32'h20, 3, -1, 0, 1'b1, -1);
    run_req(1'b0, 32'h30, 0, -1, 0, 1'b0, -1);
    run_req(1'b0, 32'hFFFF_FFFF, 2, -1, 0, 1'b0, -1);
    run_req(1'b0, 32'h40, 1, 0, 500, 1'b0, -1);
    run_req(1'b1, 32'h41, 1, -1, 0, 1'b0, -1);
    run_req(1'b1, 32'h50, 1, -1, 0, 1'b0, 100);
    run_req(1'b1, 32'h51, 1, -1, 0, 1'b0, -1);
    for (int r = 0; r < 5; r++)
      run_req(1'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(1) != 0 ? 508 : 515, 1'($urandom), -1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/emmc_xfer_ctrl.md
# emmc_xfer_ctrl

Request front-end sitting directly upstream of the eMMC state machine. It accepts multi-block read and write requests from the system side and splits them into single-block transfers on the state machine's start/ready interface. It stages each 512-byte block in an internal buffer: write data is filled from the system before issue, and read data is captured from the state machine and then drained to the system with backpressure.

## Interface

Parameters:
- `BLK_BYTES`, default 512: bytes per block; buffer depth.
- `CNT_WIDTH`, default 16: width of the request block count.

Ports (clock and reset first):
- `clk_i`  in  1  system clock; the same clock as the state machine.
- `arst_ni`  in  1  reset, asynchronous and active-low; one clock; reset is asynchronous and active-low.
- `req_valid_i`  in  1  request strobe.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_blk_idx_i`  in  32  first block address.
- `req_blk_cnt_i`  in  CNT_WIDTH  number of blocks.
- `wr_data_i`  in  8  write byte from the system.
- `wr_valid_i`  in  1  write byte valid.
- `wr_ready_o`  out  1  write byte accepted.
- `rd_data_o`  out  8  read byte to the system.
- `rd_valid_o`  out  1  read byte valid.
- `rd_ready_i`  in  1  system accepts the read byte.
- `done_o`  out  1  one-cycle pulse at request completion.
- `err_o`  out  1  one-cycle pulse, coincident with `done_o`, if any block's byte count was not `BLK_BYTES`.
- `sm_ready_i`  in  1  state machine idle.
- `sm_start_o`  out  1  one-cycle start to the state machine.
- `sm_we_o`  out  1  transfer direction to the state machine.
- `sm_blk_idx_o`  out  32  block address to the state machine.
- `sm_blk_cnt_o`  out  CNT_WIDTH  fixed at 1.
- `sm_dat_o`  out  8  write byte to the state machine.
- `sm_dat_i`  in  8  read byte from the state machine.
- `sm_dvalid_i`  in  1  byte strobe from the state machine (consume on write, capture on read).

## Operation

- **Buffer:** `BLK_BYTES` x 8 memory with a pointer of $clog2(`BLK_BYTES`)+1 bits. The pointer resets to 0 at the start of every fill, capture, drain and transfer phase.

- **State machine states:** IDLE, WR_FILL, WR_ISSUE, WR_XFER, RD_ISSUE, RD_XFER, RD_DRAIN, NEXT.
  - **IDLE:** `req_ready_o`=1. On handshake, latch `we`, `addr`=`req_blk_idx_i` and `remaining`=`req_blk_cnt_i`.
    - If `remaining`==0: go to NEXT (no state machine activity).
    - Otherwise go to WR_FILL for a write, or RD_ISSUE for a read.
  - **WR_FILL:** `wr_ready_o`=1. Each `wr_valid_i` writes buf[ptr] and increments ptr. After byte `BLK_BYTES`-1, go to WR_ISSUE.
  - **WR_ISSUE / RD_ISSUE:** wait for `sm_ready_i`=1, then pulse `sm_start_o` for one cycle with `sm_we_o`, `sm_blk_idx_o`=`addr` and `sm_blk_cnt_o`=1 stable. Then go to WR_XFER or RD_XFER.
  - **WR_XFER:** `sm_dat_o` = buf[ptr], registered. Byte 0 is present before `sm_start_o`. Each `sm_dvalid_i` advances ptr, and the next byte appears the following cycle. Exit on the `sm_ready_i` 0->1 edge seen after start; go to NEXT.
  - **RD_XFER:** each `sm_dvalid_i` writes `sm_dat_i` to buf[ptr] and increments ptr. Strobes beyond `BLK_BYTES` are dropped. Exit on the `sm_ready_i` 0->1 edge; go to RD_DRAIN.
  - **RD_DRAIN:** present buf[ptr] with `rd_valid_o`=1; ptr advances on `rd_valid_o` & `rd_ready_i`. After `BLK_BYTES` beats, go to NEXT. Only the captured bytes are drained; bytes never captured read as stale.
  - **NEXT:** decrement `remaining` and increment `addr` (mod 2^32; 32'hFFFFFFFF wraps to 0).
    - If `remaining` is now 0: pulse `done_o` (and `err_o` if flagged), then go to IDLE.
    - Otherwise go to WR_FILL or RD_ISSUE.
    - For a zero-count request: `done_o` pulses and the block returns to IDLE without decrementing.
- **Byte-count check:** the per-block capture/consume count is compared to `BLK_BYTES` at XFER exit. A mismatch sets the sticky error flag for the current request; the flag clears on the next request accept.
- **Mid-request inputs:** `req_valid_i` while busy is ignored (`req_ready_o`=0).
- **Reset:** `arst_ni` low at any point aborts any transfer.
  - Outputs go to 0: `req_ready_o`, `wr_ready_o`, `rd_valid_o`, `rd_data_o`, `done_o`, `err_o`, `sm_start_o`, `sm_we_o`, `sm_blk_idx_o`, `sm_dat_o`.
  - `sm_blk_cnt_o`=1.
  - State goes to IDLE; `req_ready_o` becomes 1 on the first clock after release.

## Timing

- Request accept to first `wr_ready_o`: 1 cycle.
- Last fill byte to `sm_start_o`: at least 1 cycle, or the first cycle `sm_ready_i`=1 thereafter.
- `sm_start_o` is never asserted while `sm_ready_i`=0. It is never asserted twice within one block.
- The ready-rise detection is ignored for the first 2 cycles after `sm_start_o`, so a late ready drop does not cause a false completion.
- XFER exit to RD_DRAIN's first `rd_valid_o`: 2 cycles (memory read latency 1).
- `rd_data_o` is stable while `rd_valid_o` & !`rd_ready_i`.
- Last beat (drain or XFER exit) to `done_o`: 1 cycle. `req_ready_o` rises the cycle after `done_o`.

## Test plan

- **Single-block write:** req we=1, idx=0x10, cnt=1; push bytes 0..255,0..255. Expect one `sm_start_o` with idx 0x10, cnt 1. `sm_dat_o` sequence equals the pushed bytes over 512 `sm_dvalid_i`. `done_o`=1 and `err_o`=0.
- **Three-block read with throttled drain:** idx=0x20, cnt=3, `rd_ready_i` toggling 1/0. Expect starts at idx 0x20, 0x21, 0x22. Each start occurs only after the previous drain completes. The 1536 drained bytes equal the stimulus, and `rd_data_o` holds steady while stalled.
- **Zero count:** req cnt=0. Expect `done_o` 1 cycle after accept and no `sm_start_o`.
- **Address wrap:** read idx=32'hFFFFFFFF, cnt=2. Expect the second start at idx 0.
- **Short block:** on read, the model issues 500 `sm_dvalid_i` then raises ready. Expect `err_o`=1 with `done_o`, 512 drained beats, and the next request's `err_o`=0.
- **Reset mid-transfer:** assert `arst_ni` during WR_XFER at byte 100. Expect all outputs at reset values immediately. After release, expect `req_ready_o`=1 next cycle, and a fresh write completes correctly.
